// File: rtl/regblock_pkg.sv
// Shared types and the byte-enable merge helper for the multi-port register block.
package regblock_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  // Widest entry the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_W  = 256;
  localparam int MAX_BE = MAX_W / 8;

  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_v,
                                                 input logic [MAX_W-1:0]  new_v,
                                                 input logic [MAX_BE-1:0] be);
    logic [MAX_W-1:0] r;
    r = old_v;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regblock_clr_fsm.sv
// Bulk-clear sequencer: walks ptr over every entry, then pulses done for one cycle.
//
// state | meaning
// IDLE  | waiting for clr_req; writes allowed
// CLEAR | zeroing entry[ptr] each cycle, ptr counts up to DEPTH-1
// DONE  | one-cycle completion pulse, then back to IDLE
module regblock_clr_fsm
  import regblock_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ptr,
  output logic          clr_we
);

  clr_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      clr_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state  <= CLEAR;
            ptr    <= '0;
            busy   <= 1'b1;
            clr_we <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + AW'(1);
          if (ptr == AW'(DEPTH - 1)) begin
            state  <= DONE;
            clr_we <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          clr_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regblock_mp.sv
// Parametrised register block: byte-enable writes, NRD registered read ports with
// write-to-read bypass, and a sequenced bulk clear that looks atomic to readers.
module regblock_mp
  import regblock_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_index,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_ready,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_index,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    clr_ptr;
  logic             clr_we;
  logic             wr_acc;
  logic [WIDTH-1:0] wr_merged;

  regblock_clr_fsm #(.DEPTH(DEPTH)) u_clr_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (clr_busy),
    .done    (clr_done),
    .ptr     (clr_ptr),
    .clr_we  (clr_we)
  );

  assign wr_ready  = ~clr_busy;
  assign wr_acc    = wr_en & wr_ready;
  assign wr_merged = WIDTH'(be_merge(MAX_W'(mem[wr_index]), MAX_W'(wr_data), MAX_BE'(wr_be)));

  // clr_we and wr_acc are mutually exclusive because wr_ready is low for the whole clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (wr_acc) begin
      mem[wr_index] <= wr_merged;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] rd_q;
    logic             vld_q;

    assign idx = rd_index[i*AW +: AW];

    always_comb begin
      rd_next = mem[idx];
      if (clr_busy) rd_next = '0;
      else if (wr_acc && (wr_index == idx)) rd_next = wr_merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rd_en[i];
        if (rd_en[i]) rd_q <= rd_next;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = rd_q;
    assign rd_valid[i]               = vld_q;
  end

endmodule

// File: tb/tb_regblock_mp.sv
// Scoreboard bench for regblock_mp: reference model pushes expected read data,
// a monitor pops it on rd_valid; a parallel miter pair checks lock-step equality.
module tb_regblock_mp;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int A  = 2;
  localparam int MW = 16;
  localparam int MD = 8;
  localparam int MN = 3;
  localparam int MA = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [A-1:0]   wr_index;
  logic [W/8-1:0] wr_be;
  logic [W-1:0]   wr_data;
  logic           wr_ready;
  logic [N-1:0]   rd_en;
  logic [N*A-1:0] rd_index;
  logic [N*W-1:0] rd_data;
  logic [N-1:0]   rd_valid;
  logic           clr_req;
  logic           clr_busy;
  logic           clr_done;

  logic             m_wr_en;
  logic [MA-1:0]    m_wr_index;
  logic [MW/8-1:0]  m_wr_be;
  logic [MW-1:0]    m_wr_data;
  logic [MN-1:0]    m_rd_en;
  logic [MN*MA-1:0] m_rd_index;
  logic             m_clr_req;
  logic             a_wr_ready, b_wr_ready, a_busy, b_busy, a_done, b_done;
  logic [MN*MW-1:0] a_rd_data, b_rd_data;
  logic [MN-1:0]    a_rd_valid, b_rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regblock_mp #(.WIDTH(W), .DEPTH(D), .NRD(N)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_index(wr_index), .wr_be(wr_be),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_en(rd_en), .rd_index(rd_index),
    .rd_data(rd_data), .rd_valid(rd_valid), .clr_req(clr_req), .clr_busy(clr_busy),
    .clr_done(clr_done)
  );

  regblock_mp #(.WIDTH(MW), .DEPTH(MD), .NRD(MN)) u_mit_a (
    .clk(clk), .rst_n(rst_n), .wr_en(m_wr_en), .wr_index(m_wr_index), .wr_be(m_wr_be),
    .wr_data(m_wr_data), .wr_ready(a_wr_ready), .rd_en(m_rd_en), .rd_index(m_rd_index),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .clr_req(m_clr_req), .clr_busy(a_busy),
    .clr_done(a_done)
  );

  regblock_mp #(.WIDTH(MW), .DEPTH(MD), .NRD(MN)) u_mit_b (
    .clk(clk), .rst_n(rst_n), .wr_en(m_wr_en), .wr_index(m_wr_index), .wr_be(m_wr_be),
    .wr_data(m_wr_data), .wr_ready(b_wr_ready), .rd_en(m_rd_en), .rd_index(m_rd_index),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .clr_req(m_clr_req), .clr_busy(b_busy),
    .clr_done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                             input logic [W/8-1:0] be);
    logic [W-1:0] mask;
    mask = '0;
    for (int k = 0; k < W/8; k++) mask[8*k +: 8] = {8{be[k]}};
    return (o & ~mask) | (n & mask);
  endfunction

  // Reference model: a clear is seen as instantly zeroing everything, followed by
  // DEPTH+1 cycles in which writes are refused and reads return zero.
  logic [W-1:0] m_mem [D];
  int           m_left;
  logic [N-1:0] m_valid;
  logic [W-1:0] hold_d [N];
  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int e = 0; e < D; e++) m_mem[e] = '0;
        m_left  = 0;
        m_valid = '0;
        for (int p = 0; p < N; p++) hold_d[p] = '0;
        q0.delete();
        q1.delete();
      end else begin
        automatic bit           busy = (m_left > 0);
        automatic bit           acc  = wr_en && !busy;
        automatic logic [A-1:0] idx;
        automatic logic [W-1:0] v;
        for (int p = 0; p < N; p++) begin
          if (rd_en[p]) begin
            idx = rd_index[p*A +: A];
            if (busy) v = '0;
            else if (acc && idx == wr_index) v = ref_merge(m_mem[idx], wr_data, wr_be);
            else v = m_mem[idx];
            if (p == 0) q0.push_back(v);
            else q1.push_back(v);
          end
        end
        m_valid = rd_en;
        if (acc) m_mem[wr_index] = ref_merge(m_mem[wr_index], wr_data, wr_be);
        if (m_left > 0) m_left--;
        else if (clr_req) begin
          m_left = D + 1;
          for (int e = 0; e < D; e++) m_mem[e] = '0;
        end
      end
    end
  end

  // Monitor: status against the model, read data popped from the scoreboard on rd_valid.
  initial begin
    forever begin
      @(negedge clk);
      check("clr_busy", 64'(clr_busy), 64'(m_left > 0));
      check("clr_done", 64'(clr_done), 64'(m_left == 1));
      check("wr_ready", 64'(wr_ready), 64'(m_left == 0));
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      for (int p = 0; p < N; p++) begin
        if (rd_valid[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            check("sb_underflow", 64'(1), 64'(0));
          end else begin
            hold_d[p] = (p == 0) ? q0.pop_front() : q1.pop_front();
            check("rd_data", 64'(rd_data[p*W +: W]), 64'(hold_d[p]));
          end
        end else begin
          check("rd_hold", 64'(rd_data[p*W +: W]), 64'(hold_d[p]));
        end
      end
    end
  end

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = '0; clr_req = 1'b0;
  endtask

  task automatic main_seq();
    // single-port write then read
    @(negedge clk);
    wr_en = 1'b1; wr_index = 2'd2; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 2'b01; rd_index = {2'd0, 2'd2};
    @(negedge clk);
    check("t2_data", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    check("t2_valid", 64'(rd_valid[0]), 64'd1);
    rd_en = '0;
    // partial byte-enable write
    wr_en = 1'b1; wr_index = 2'd2; wr_data = 32'h11223344; wr_be = 4'b0101;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 2'b01; rd_index = {2'd0, 2'd2};
    @(negedge clk);
    check("t3_merge", 64'(rd_data[31:0]), 64'h0000_0000_DE22_BE44);
    // same-edge write and dual read of that index
    wr_en = 1'b1; wr_index = 2'd1; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd_en = 2'b11; rd_index = {2'd1, 2'd1};
    @(negedge clk);
    idle_inputs();
    check("t4_bypass0", 64'(rd_data[31:0]), 64'h0000_0000_A5A5_A5A5);
    check("t4_bypass1", 64'(rd_data[63:32]), 64'h0000_0000_A5A5_A5A5);
    // bulk clear timing, write during clear dropped
    clr_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("t5_busy", 64'(clr_busy), 64'(k <= 5));
      check("t5_done", 64'(clr_done), 64'(k == 5));
      check("t5_ready", 64'(wr_ready), 64'(k >= 6));
      if (k == 1) clr_req = 1'b0;
      if (k == 2) begin
        wr_en = 1'b1; wr_index = 2'd3; wr_data = 32'h12345678; wr_be = 4'hF;
      end
      if (k == 3) wr_en = 1'b0;
    end
    rd_en = 2'b11; rd_index = {2'd1, 2'd0};
    @(negedge clk);
    check("t5_clr01", 64'(rd_data), 64'd0);
    rd_index = {2'd3, 2'd2};
    @(negedge clk);
    check("t5_clr23", 64'(rd_data), 64'd0);
    rd_en = '0;
    // reset in the middle of a clear
    wr_en = 1'b1; wr_index = 2'd3; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0; rd_en = 2'b11; rd_index = {2'd3, 2'd3};
    @(negedge clk);
    check("t1_pre_valid", 64'(rd_valid), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", 64'(clr_busy), 64'd0);
    check("t1_ready", 64'(wr_ready), 64'd1);
    check("t1_valid", 64'(rd_valid), 64'd0);
    rd_en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 2'b11; rd_index = {2'd1, 2'd3};
    @(negedge clk);
    check("t1_zero13", 64'(rd_data), 64'd0);
    rd_en = '0;
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      wr_en    = 1'($urandom);
      wr_index = A'($urandom);
      wr_be    = 4'($urandom);
      wr_data  = $urandom;
      rd_en    = N'($urandom);
      rd_index = (N*A)'($urandom);
      clr_req  = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (8) @(negedge clk);
  endtask

  task automatic miter_seq();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      check("miter", 64'({a_rd_data, a_rd_valid, a_busy, a_done, a_wr_ready}),
                     64'({b_rd_data, b_rd_valid, b_busy, b_done, b_wr_ready}));
      m_wr_en    = 1'($urandom);
      m_wr_index = MA'($urandom);
      m_wr_be    = 2'($urandom);
      m_wr_data  = 16'($urandom);
      m_rd_en    = MN'($urandom);
      m_rd_index = (MN*MA)'($urandom);
      m_clr_req  = ($urandom_range(0, 31) == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    wr_index = '0; wr_be = '0; wr_data = '0; rd_index = '0;
    m_wr_en = 1'b0; m_wr_index = '0; m_wr_be = '0; m_wr_data = '0;
    m_rd_en = '0; m_rd_index = '0; m_clr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(wr_ready), 64'd1);
    check("rst_data", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    fork
      main_seq();
      miter_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
